// File: rtl/apb_requester.sv
// APB initiator: queues read/write commands from a request port and runs each one as a
// SETUP+ACCESS transfer, returning read data or a timeout error on the response port.
module apb_requester #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } state_t;

   state_t state_reg, state_next;

   // command queue
   logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [ENTRY_W-1:0] head;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   // transfer and response registers
   logic               pwrite_reg;
   logic [ADDR_W-1:0]  paddr_reg;
   logic [DATA_W-1:0]  pwdata_reg;
   logic [DATA_W-1:0]  rsp_rdata_reg;
   logic               rsp_err_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   logic               access_done;
   logic               timeout_hit;

   assign fifo_empty = (count_reg == '0);
   assign req_ready  = (count_reg != FIFO_FULL);
   assign push       = req_valid && req_ready;
   assign head       = mem_reg[rd_ptr_reg];

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge pclk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= {req_write, req_addr, req_wdata};
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pop         = 1'b0;
      access_done = 1'b0;
      timeout_hit = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               access_done = 1'b1;
               state_next  = ST_RESP;
            end else if ((TIMEOUT > 0) && (wait_cnt_reg == WAIT_LAST)) begin
               timeout_hit = 1'b1;
               state_next  = ST_RESP;
            end
         end
         ST_RESP: begin
            // The response handshake chains straight into the next queued transfer.
            if (rsp_ready) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = ST_SETUP;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pwrite_reg   <= 1'b0;
         paddr_reg    <= '0;
         pwdata_reg   <= '0;
         wait_cnt_reg <= '0;
      end else begin
         if (pop) begin
            {pwrite_reg, paddr_reg, pwdata_reg} <= head;
            wait_cnt_reg <= '0;
         end else if ((state_reg == ST_ACCESS) && !pready && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         if (access_done) begin
            rsp_rdata_reg <= pwrite_reg ? '0 : prdata;
            rsp_err_reg   <= 1'b0;
         end else if (timeout_hit) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
         end
      end
   end

   // Bus controls decode straight from the state so reset clears them without waiting for an edge.
   assign psel      = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
   assign penable   = (state_reg == ST_ACCESS);
   assign rsp_valid = (state_reg == ST_RESP);
   assign pwrite    = pwrite_reg;
   assign paddr     = paddr_reg;
   assign pwdata    = pwdata_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: a scripted APB slave plus hand-computed expectations.
module tb_apb_requester;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 16;

   logic              pclk = 1'b0;
   logic              presetn = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [DATA_W-1:0] req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata = '0;
   logic              pready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   apb_requester #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready)
   );

   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land on the falling edge, where outputs are sampled.
   task automatic step();
      @(posedge pclk);
      @(negedge pclk);
   endtask

   task automatic push_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      step();
      req_valid = 1'b0;
      $display("push %s addr=0x%02h data=0x%08h", wr ? "WR" : "RD", a, d);
   endtask

   // Drive the slave through an ACCESS phase; ready_at=0 means never ready.
   task automatic run_access(input int ready_at, output int cycles);
      cycles = 0;
      while (psel && penable && cycles < 40) begin
         cycles++;
         pready = (ready_at > 0) && (cycles >= ready_at);
         step();
      end
      pready = 1'b0;
   endtask

   task automatic take_rsp();
      $display("rsp rdata=0x%08h err=%0d", rsp_rdata, rsp_err);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
   endtask

   logic [ADDR_W-1:0] seen_addr [8];
   int                seen_cyc  [8];
   logic [DATA_W-1:0] seen_rdata[8];
   int                n_seen;
   int                n_rsp;
   int                cyc;
   int                bad;

   initial begin
      // reset values, held in reset
      step();
      step();
      check_eq("rst_psel", psel, 1'b0);
      check_eq("rst_penable", penable, 1'b0);
      check_eq("rst_pwrite", pwrite, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_err", rsp_err, 1'b0);
      check_eq("rst_paddr", paddr, 0);
      check_eq("rst_pwdata", pwdata, 0);
      check_eq("rst_rsp_rdata", rsp_rdata, 0);
      check_eq("rst_req_ready", req_ready, 1'b1);
      presetn = 1'b1;
      step();

      // single zero-wait write: SETUP at N+1, ACCESS at N+2, response at N+3
      pready = 1'b1;
      push_cmd(1'b1, 8'h04, 32'hDEADBEEF);
      check_eq("wr_n_psel", psel, 1'b0);
      step();
      check_eq("wr_setup_psel", psel, 1'b1);
      check_eq("wr_setup_penable", penable, 1'b0);
      check_eq("wr_setup_paddr", paddr, 8'h04);
      check_eq("wr_setup_pwrite", pwrite, 1'b1);
      check_eq("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
      step();
      check_eq("wr_access_psel", psel, 1'b1);
      check_eq("wr_access_penable", penable, 1'b1);
      check_eq("wr_access_pwdata", pwdata, 32'hDEADBEEF);
      step();
      check_eq("wr_rsp_valid", rsp_valid, 1'b1);
      check_eq("wr_rsp_err", rsp_err, 1'b0);
      check_eq("wr_rsp_rdata", rsp_rdata, 0);
      check_eq("wr_rsp_psel", psel, 1'b0);
      take_rsp();
      check_eq("wr_after_rsp_valid", rsp_valid, 1'b0);
      check_eq("wr_after_psel", psel, 1'b0);
      pready = 1'b0;

      // read with three wait states
      prdata = 32'h0000_1234;
      push_cmd(1'b0, 8'h08, 32'h0);
      step();
      step();
      check_eq("rd_in_access", penable, 1'b1);
      check_eq("rd_pwrite", pwrite, 1'b0);
      run_access(4, cyc);
      check_eq("rd_access_cycles", cyc, 4);
      check_eq("rd_rsp_valid", rsp_valid, 1'b1);
      check_eq("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
      check_eq("rd_rsp_err", rsp_err, 1'b0);
      take_rsp();
      prdata = '0;

      // timeout: slave never ready, read data must still come back as zero
      prdata = 32'hFFFF_FFFF;
      push_cmd(1'b0, 8'h10, 32'h0);
      step();
      step();
      run_access(0, cyc);
      check_eq("to_access_cycles", cyc, TIMEOUT);
      check_eq("to_rsp_valid", rsp_valid, 1'b1);
      check_eq("to_rsp_err", rsp_err, 1'b1);
      check_eq("to_rsp_rdata", rsp_rdata, 0);
      check_eq("to_psel", psel, 1'b0);
      take_rsp();
      prdata = '0;

      // fill the queue behind a stalled transfer, then drain and check ordering
      pready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check_eq("fill_ready_before_last", req_ready, 1'b1);
         push_cmd(i[0], 8'h20 + 8'(i), 32'h100 + 32'(i));
      end
      check_eq("fill_ready_full", req_ready, 1'b0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h99;
      req_wdata = 32'h99;
      step();
      req_valid = 1'b0;
      check_eq("fill_ready_still_full", req_ready, 1'b0);
      prdata    = 32'hCAFE_0000;
      pready    = 1'b1;
      rsp_ready = 1'b1;
      n_seen    = 0;
      n_rsp     = 0;
      for (int c = 0; c < 30; c++) begin
         if (psel && penable && n_seen < 8) begin
            seen_addr[n_seen] = paddr;
            seen_cyc[n_seen]  = c;
            n_seen++;
         end
         if (rsp_valid && n_rsp < 8) begin
            seen_rdata[n_rsp] = rsp_rdata;
            $display("drain rsp %0d rdata=0x%08h err=%0d", n_rsp, rsp_rdata, rsp_err);
            n_rsp++;
         end
         step();
      end
      pready    = 1'b0;
      rsp_ready = 1'b0;
      prdata    = '0;
      check_eq("fill_transfers", n_seen, 5);
      check_eq("fill_responses", n_rsp, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < n_seen) check_eq($sformatf("fill_addr%0d", i), seen_addr[i], 8'h20 + 8'(i));
         if (i > 0 && i < n_seen) check_eq($sformatf("fill_gap%0d", i), seen_cyc[i] - seen_cyc[i-1], 3);
         if (i < n_rsp) check_eq($sformatf("fill_rdata%0d", i), seen_rdata[i], i[0] ? 32'h0 : 32'hCAFE_0000);
      end

      // response held off for 10 cycles with a second command queued
      pready = 1'b1;
      push_cmd(1'b1, 8'h30, 32'hA);
      push_cmd(1'b1, 8'h34, 32'hB);
      step();
      step();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (psel || !rsp_valid) bad++;
         step();
      end
      check_eq("hold_stall_bad_cycles", bad, 0);
      check_eq("hold_paddr_kept", paddr, 8'h30);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_eq("hold_next_psel", psel, 1'b1);
      check_eq("hold_next_penable", penable, 1'b0);
      check_eq("hold_next_paddr", paddr, 8'h34);
      check_eq("hold_next_rsp_valid", rsp_valid, 1'b0);
      step();
      step();
      check_eq("hold_second_rsp", rsp_valid, 1'b1);
      take_rsp();

      // asynchronous reset in the middle of ACCESS with another command queued
      pready = 1'b0;
      push_cmd(1'b0, 8'h40, 32'h0);
      push_cmd(1'b1, 8'h44, 32'h5);
      step();
      check_eq("arst_in_access", penable, 1'b1);
      #2 presetn = 1'b0;
      #1;
      check_eq("arst_psel_now", psel, 1'b0);
      check_eq("arst_penable_now", penable, 1'b0);
      check_eq("arst_rsp_valid_now", rsp_valid, 1'b0);
      check_eq("arst_paddr_now", paddr, 0);
      @(negedge pclk);
      presetn = 1'b1;
      step();
      step();
      step();
      check_eq("arst_idle_psel", psel, 1'b0);
      check_eq("arst_empty_ready", req_ready, 1'b1);
      check_eq("arst_rsp_valid", rsp_valid, 1'b0);
      pready = 1'b1;
      push_cmd(1'b1, 8'h50, 32'h77);
      step();
      check_eq("arst_next_psel", psel, 1'b1);
      check_eq("arst_next_paddr", paddr, 8'h50);
      step();
      step();
      take_rsp();
      pready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
